// File: rtl/fios_ctrl_pkg.sv
// rtl/fios_ctrl_pkg.sv - shared types, control codes and timing helpers for the 4A FIOS sequencer
package fios_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // DSP OPMODE words driven per PE
    localparam logic [8:0] OP_IDLE   = 9'h000;
    localparam logic [8:0] OP_AB     = 9'h005;
    localparam logic [8:0] OP_M      = 9'h035;
    localparam logic [8:0] OP_MP_ACC = 9'h0A5;

    // A operand mux codes
    localparam logic [1:0] SEL_A      = 2'd1;
    localparam logic [1:0] SEL_LOW    = 2'd2;
    localparam logic [1:0] SEL_M      = 2'd3;

    // B operand mux codes
    localparam logic [1:0] SEL_B      = 2'd1;
    localparam logic [1:0] SEL_PPRIME = 2'd2;
    localparam logic [1:0] SEL_P      = 2'd3;

    // C source mux codes
    localparam logic [1:0] C_ZERO   = 2'd0;
    localparam logic [1:0] C_DIRECT = 2'd1;
    localparam logic [1:0] C_DLY1   = 2'd2;
    localparam logic [1:0] C_DLY2   = 2'd3;

    // Cycles between consecutive PEs starting their windows
    function automatic int pe_delay(input int dsp_reg_level, input int creg);
        return 2 * dsp_reg_level + creg + 2;
    endfunction

    // Cycles from the last PE reaching k=2 to the first valid result word
    function automatic int out_lat(input int dsp_reg_level, input int creg);
        return dsp_reg_level + creg + 1;
    endfunction

    // PE0 always takes a zero C; downstream PEs pick the tap matching the pipeline depth
    function automatic logic [1:0] c_sel_code(input int pe, input int dsp_reg_level);
        if (pe == 0)
            return C_ZERO;
        case (dsp_reg_level)
            1:       return C_DIRECT;
            2:       return C_DLY1;
            default: return C_DLY2;
        endcase
    endfunction

endpackage

// File: rtl/fios_pe_sched.sv
// rtl/fios_pe_sched.sv - per-PE window counter with registered control decode
module fios_pe_sched
    import fios_ctrl_pkg::*;
#(
    parameter int         S      = 8,
    parameter int         CREG   = 1,
    parameter logic [1:0] C_CODE = C_ZERO
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       go_i,
    output logic       a_reg_en,
    output logic       m_reg_en,
    output logic [1:0] mux_a_sel,
    output logic [1:0] mux_b_sel,
    output logic [1:0] mux_c_sel,
    output logic       creg_en,
    output logic [8:0] opmode,
    output logic       res_delay_en,
    output logic       c_input_delay_en
);

    localparam int   KW       = $clog2(S + 2);
    localparam logic CREG_BIT = (CREG != 0);

    logic          active;
    logic [KW-1:0] k;
    logic [KW-1:0] cur_k;
    logic          in_win;

    // The go cycle itself is k=0, so decode from zero while the counter catches up
    always_comb begin
        in_win = go_i | active;
        cur_k  = go_i ? '0 : k;
    end

    // Step k through 0..S+1 and register the control word for the current k
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            active           <= 1'b0;
            k                <= '0;
            a_reg_en         <= 1'b0;
            m_reg_en         <= 1'b0;
            mux_a_sel        <= 2'd0;
            mux_b_sel        <= 2'd0;
            mux_c_sel        <= C_ZERO;
            creg_en          <= 1'b0;
            opmode           <= OP_IDLE;
            res_delay_en     <= 1'b0;
            c_input_delay_en <= 1'b0;
        end else begin
            mux_c_sel <= C_CODE;

            if (go_i) begin
                active <= 1'b1;
                k      <= KW'(1);
            end else if (active) begin
                if (k == KW'(S + 1)) begin
                    active <= 1'b0;
                    k      <= '0;
                end else begin
                    k <= k + 1'b1;
                end
            end

            a_reg_en         <= 1'b0;
            m_reg_en         <= 1'b0;
            mux_a_sel        <= 2'd0;
            mux_b_sel        <= 2'd0;
            creg_en          <= 1'b0;
            opmode           <= OP_IDLE;
            res_delay_en     <= 1'b0;
            c_input_delay_en <= 1'b0;

            if (in_win) begin
                if (cur_k == '0) begin
                    a_reg_en         <= 1'b1;
                    mux_a_sel        <= SEL_A;
                    mux_b_sel        <= SEL_B;
                    opmode           <= OP_AB;
                    creg_en          <= CREG_BIT;
                    c_input_delay_en <= 1'b1;
                end else if (cur_k == KW'(1)) begin
                    m_reg_en         <= 1'b1;
                    mux_a_sel        <= SEL_LOW;
                    mux_b_sel        <= SEL_PPRIME;
                    opmode           <= OP_M;
                end else begin
                    mux_a_sel        <= SEL_M;
                    mux_b_sel        <= SEL_P;
                    opmode           <= OP_MP_ACC;
                    res_delay_en     <= 1'b1;
                    c_input_delay_en <= 1'b1;
                    creg_en          <= CREG_BIT;
                end
            end
        end
    end

endmodule

// File: rtl/fios_ctrl_nocasc_4a.sv
// rtl/fios_ctrl_nocasc_4a.sv - sequencer for the non-cascaded 4A FIOS multiplier, EXPAND configuration
module fios_ctrl_nocasc_4a
    import fios_ctrl_pkg::*;
#(
    parameter int s     = 8,
    parameter int ABREG = 1,
    parameter int MREG  = 1,
    parameter int CREG  = 1
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 word_rd_en_o,
    output logic [$clog2(s)-1:0] word_idx_o,
    output logic [s-1:0]         a_reg_en_o,
    output logic [s-1:0]         m_reg_en_o,
    output logic [2*s-1:0]       mux_A_sel_o,
    output logic [2*s-1:0]       mux_B_sel_o,
    output logic [2*s-1:0]       mux_C_sel_o,
    output logic [s-1:0]         CREG_en_o,
    output logic [9*s-1:0]       OPMODE_o,
    output logic [s-1:0]         RES_delay_en_o,
    output logic [s-1:0]         C_input_delay_en_o,
    output logic                 FIOS_input_sel_o,
    output logic                 res_valid_o,
    output logic [$clog2(s)-1:0] res_idx_o,
    output logic                 done_o
);

    localparam int DSP_REG_LEVEL = ABREG + MREG + 1;
    localparam int PE_DELAY      = pe_delay(DSP_REG_LEVEL, CREG);
    localparam int OUT_LAT       = out_lat(DSP_REG_LEVEL, CREG);
    localparam int IW            = $clog2(s);
    localparam int CHAIN         = (s - 1) * PE_DELAY + 1;
    // Cycle numbers below count from the start-acceptance cycle (= 0)
    localparam int LAST_GO       = 1 + (s - 1) * PE_DELAY;
    localparam int DRAIN_AT      = LAST_GO + s + 1;
    localparam int RES_FIRST     = LAST_GO + 2 + OUT_LAT;
    localparam int DONE_AT       = RES_FIRST + s;
    localparam int CW            = $clog2(DONE_AT + 1);

    state_t           state;
    logic [CW-1:0]    cyc;
    logic [CHAIN-1:0] go_sr;
    logic             accept;

    assign accept           = (state == ST_IDLE) && start_i;
    assign FIOS_input_sel_o = 1'b0;

    // Top-level run control: cycle counter, busy and the done pulse
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state  <= ST_IDLE;
            cyc    <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state  <= ST_RUN;
                        cyc    <= CW'(1);
                        busy_o <= 1'b1;
                    end
                end
                ST_RUN: begin
                    cyc <= cyc + 1'b1;
                    if (cyc == CW'(DRAIN_AT))
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    cyc <= cyc + 1'b1;
                    if (cyc == CW'(DONE_AT - 1)) begin
                        state  <= ST_DONE;
                        done_o <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    cyc    <= '0;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

    // Go chain: bit j*PE_DELAY is the go pulse of PE j
    always_ff @(posedge clock_i) begin
        if (reset_i)
            go_sr <= '0;
        else
            go_sr <= {go_sr[CHAIN-2:0], accept};
    end

    // Operand word fetch strobe for s cycles after acceptance
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            word_rd_en_o <= 1'b0;
            word_idx_o   <= '0;
        end else begin
            word_rd_en_o <= accept | (word_rd_en_o && (word_idx_o != IW'(s - 1)));
            if (!accept && word_rd_en_o && (word_idx_o != IW'(s - 1)))
                word_idx_o <= word_idx_o + 1'b1;
            else
                word_idx_o <= '0;
        end
    end

    // Result word flags, one cycle early because the outputs are registered
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            res_valid_o <= 1'b0;
            res_idx_o   <= '0;
        end else if ((state == ST_RUN || state == ST_DRAIN) &&
                     (cyc >= CW'(RES_FIRST - 1)) && (cyc <= CW'(RES_FIRST + s - 2))) begin
            res_valid_o <= 1'b1;
            res_idx_o   <= IW'(cyc - CW'(RES_FIRST - 1));
        end else begin
            res_valid_o <= 1'b0;
            res_idx_o   <= '0;
        end
    end

    for (genvar i = 0; i < s; i++) begin : g_pe
        fios_pe_sched #(
            .S      (s),
            .CREG   (CREG),
            .C_CODE (c_sel_code(i, DSP_REG_LEVEL))
        ) u_sched (
            .clock_i          (clock_i),
            .reset_i          (reset_i),
            .go_i             (go_sr[i*PE_DELAY]),
            .a_reg_en         (a_reg_en_o[i]),
            .m_reg_en         (m_reg_en_o[i]),
            .mux_a_sel        (mux_A_sel_o[2*i +: 2]),
            .mux_b_sel        (mux_B_sel_o[2*i +: 2]),
            .mux_c_sel        (mux_C_sel_o[2*i +: 2]),
            .creg_en          (CREG_en_o[i]),
            .opmode           (OPMODE_o[9*i +: 9]),
            .res_delay_en     (RES_delay_en_o[i]),
            .c_input_delay_en (C_input_delay_en_o[i])
        );
    end

endmodule

// File: tb/tb_fios_ctrl_nocasc_4a.sv
// tb/tb_fios_ctrl_nocasc_4a.sv - self-checking bench for the 4A FIOS sequencer
module tb_fios_ctrl_nocasc_4a;

    localparam int S  = 4;
    localparam int PD = 9;
    localparam int OL = 5;
    localparam int D  = 1 + (S - 1) * PD + 2 + OL + S;
    localparam int R0 = D - S;

    logic clock_i = 1'b0;
    logic reset_i = 1'b1;
    logic start_i = 1'b0;

    logic         busy_o, word_rd_en_o, FIOS_input_sel_o, res_valid_o, done_o;
    logic [1:0]   word_idx_o, res_idx_o;
    logic [S-1:0] a_reg_en_o, m_reg_en_o, CREG_en_o, RES_delay_en_o, C_input_delay_en_o;
    logic [2*S-1:0] mux_A_sel_o, mux_B_sel_o, mux_C_sel_o;
    logic [9*S-1:0] OPMODE_o;

    logic         l1_busy, l1_rd, l1_fsel, l1_rv, l1_done;
    logic [1:0]   l1_widx, l1_ridx;
    logic [S-1:0] l1_a, l1_m, l1_cr, l1_rd_en, l1_cd;
    logic [2*S-1:0] l1_ma, l1_mb, l1_mc;
    logic [9*S-1:0] l1_op;

    logic         l3_busy, l3_rd, l3_fsel, l3_rv, l3_done;
    logic [1:0]   l3_widx, l3_ridx;
    logic [S-1:0] l3_a, l3_m, l3_cr, l3_rd_en, l3_cd;
    logic [2*S-1:0] l3_ma, l3_mb, l3_mc;
    logic [9*S-1:0] l3_op;

    always #5 clock_i = ~clock_i;

    fios_ctrl_nocasc_4a #(.s(S), .ABREG(1), .MREG(1), .CREG(1)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .busy_o(busy_o),
        .word_rd_en_o(word_rd_en_o), .word_idx_o(word_idx_o), .a_reg_en_o(a_reg_en_o),
        .m_reg_en_o(m_reg_en_o), .mux_A_sel_o(mux_A_sel_o), .mux_B_sel_o(mux_B_sel_o),
        .mux_C_sel_o(mux_C_sel_o), .CREG_en_o(CREG_en_o), .OPMODE_o(OPMODE_o),
        .RES_delay_en_o(RES_delay_en_o), .C_input_delay_en_o(C_input_delay_en_o),
        .FIOS_input_sel_o(FIOS_input_sel_o), .res_valid_o(res_valid_o),
        .res_idx_o(res_idx_o), .done_o(done_o));

    fios_ctrl_nocasc_4a #(.s(S), .ABREG(0), .MREG(0), .CREG(1)) dut_l1 (
        .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .busy_o(l1_busy),
        .word_rd_en_o(l1_rd), .word_idx_o(l1_widx), .a_reg_en_o(l1_a),
        .m_reg_en_o(l1_m), .mux_A_sel_o(l1_ma), .mux_B_sel_o(l1_mb),
        .mux_C_sel_o(l1_mc), .CREG_en_o(l1_cr), .OPMODE_o(l1_op),
        .RES_delay_en_o(l1_rd_en), .C_input_delay_en_o(l1_cd),
        .FIOS_input_sel_o(l1_fsel), .res_valid_o(l1_rv),
        .res_idx_o(l1_ridx), .done_o(l1_done));

    fios_ctrl_nocasc_4a #(.s(S), .ABREG(2), .MREG(0), .CREG(1)) dut_l3 (
        .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .busy_o(l3_busy),
        .word_rd_en_o(l3_rd), .word_idx_o(l3_widx), .a_reg_en_o(l3_a),
        .m_reg_en_o(l3_m), .mux_A_sel_o(l3_ma), .mux_B_sel_o(l3_mb),
        .mux_C_sel_o(l3_mc), .CREG_en_o(l3_cr), .OPMODE_o(l3_op),
        .RES_delay_en_o(l3_rd_en), .C_input_delay_en_o(l3_cd),
        .FIOS_input_sel_o(l3_fsel), .res_valid_o(l3_rv),
        .res_idx_o(l3_ridx), .done_o(l3_done));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int run_start = -1;
    bit rst_prev = 1'b0;
    bit started = 1'b0;

    bit         rec_on = 1'b0;
    int         rec_base = 0;
    logic [8:0] hist [S][64];
    int         a_first [S];
    int         m_cnt [S];
    int         done_cnt = 0;
    int         done_rel = -1;
    int         rd_first = -1;
    int         rd_last = -1;
    int         idx_last = -1;
    int         total_done = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: tracks which cycle a run was accepted in, from the pins alone
    initial forever begin
        @(posedge clock_i);
        if (reset_i)
            run_start = -1;
        else if ((run_start < 0 || cyc - run_start > D) && start_i)
            run_start = cyc;
        rst_prev = reset_i;
        if (reset_i)
            started = 1'b1;
        cyc++;
    end

    // Compare process: derive every output from the run-relative cycle number
    initial forever begin
        int c, k, r;
        logic         e_busy, e_rd, e_rv, e_done;
        logic [1:0]   e_widx, e_ridx;
        logic [S-1:0] e_a, e_m, e_cr, e_rde, e_cd;
        logic [2*S-1:0] e_ma, e_mb, e_mc;
        logic [9*S-1:0] e_op;
        @(negedge clock_i);
        if (started) begin
            c = (run_start < 0) ? -1000 : cyc - run_start;
            e_busy = (c >= 1 && c <= D);
            e_rd   = (c >= 1 && c <= S);
            e_widx = e_rd ? 2'(c - 1) : 2'd0;
            e_rv   = (c >= R0 && c < R0 + S);
            e_ridx = e_rv ? 2'(c - R0) : 2'd0;
            e_done = (c == D);
            e_a = '0; e_m = '0; e_cr = '0; e_rde = '0; e_cd = '0;
            e_ma = '0; e_mb = '0; e_mc = '0; e_op = '0;
            for (int i = 0; i < S; i++) begin
                k = c - 2 - i * PD;
                if (k == 0) begin
                    e_a[i] = 1'b1; e_ma[2*i +: 2] = 2'd1; e_mb[2*i +: 2] = 2'd1;
                    e_op[9*i +: 9] = 9'h005; e_cr[i] = 1'b1; e_cd[i] = 1'b1;
                end else if (k == 1) begin
                    e_m[i] = 1'b1; e_ma[2*i +: 2] = 2'd2; e_mb[2*i +: 2] = 2'd2;
                    e_op[9*i +: 9] = 9'h035;
                end else if (k >= 2 && k <= S + 1) begin
                    e_ma[2*i +: 2] = 2'd3; e_mb[2*i +: 2] = 2'd3;
                    e_op[9*i +: 9] = 9'h0A5; e_rde[i] = 1'b1; e_cd[i] = 1'b1; e_cr[i] = 1'b1;
                end
                if (!rst_prev && i > 0)
                    e_mc[2*i +: 2] = 2'd3;
            end
            chk("busy", 64'(busy_o), 64'(e_busy));
            chk("word_rd_en", 64'(word_rd_en_o), 64'(e_rd));
            chk("word_idx", 64'(word_idx_o), 64'(e_widx));
            chk("a_reg_en", 64'(a_reg_en_o), 64'(e_a));
            chk("m_reg_en", 64'(m_reg_en_o), 64'(e_m));
            chk("mux_A_sel", 64'(mux_A_sel_o), 64'(e_ma));
            chk("mux_B_sel", 64'(mux_B_sel_o), 64'(e_mb));
            chk("mux_C_sel", 64'(mux_C_sel_o), 64'(e_mc));
            chk("CREG_en", 64'(CREG_en_o), 64'(e_cr));
            chk("OPMODE", 64'(OPMODE_o), 64'(e_op));
            chk("RES_delay_en", 64'(RES_delay_en_o), 64'(e_rde));
            chk("C_input_delay_en", 64'(C_input_delay_en_o), 64'(e_cd));
            chk("FIOS_input_sel", 64'(FIOS_input_sel_o), 64'd0);
            chk("res_valid", 64'(res_valid_o), 64'(e_rv));
            chk("res_idx", 64'(res_idx_o), 64'(e_ridx));
            chk("done", 64'(done_o), 64'(e_done));
            if (done_o === 1'b1)
                total_done++;
            if (rec_on) begin
                r = cyc - rec_base;
                for (int i = 0; i < S; i++) begin
                    if (r >= 0 && r < 64)
                        hist[i][r] = OPMODE_o[9*i +: 9];
                    if (a_reg_en_o[i] === 1'b1 && a_first[i] < 0)
                        a_first[i] = r;
                    if (m_reg_en_o[i] === 1'b1)
                        m_cnt[i]++;
                end
                if (done_o === 1'b1) begin
                    done_cnt++;
                    done_rel = r;
                end
                if (word_rd_en_o === 1'b1) begin
                    if (rd_first < 0)
                        rd_first = r;
                    rd_last  = r;
                    idx_last = int'(word_idx_o);
                end
            end
        end
    end

    // Watchdog so a stuck run still ends with a report
    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    // Directed stimulus with hand-computed literal expectations
    initial begin
        int a, td;
        for (int i = 0; i < S; i++) begin
            a_first[i] = -1;
            m_cnt[i] = 0;
            for (int j = 0; j < 64; j++)
                hist[i][j] = 9'h000;
        end

        repeat (3) @(posedge clock_i);
        #1 reset_i = 1'b0;
        @(negedge clock_i);
        chk("rst_opmode", 64'(OPMODE_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_mux_c", 64'(mux_C_sel_o), 64'd0);

        repeat (2) @(posedge clock_i);
        #1;
        chk("l1_mux_c", 64'(l1_mc), 64'h54);
        chk("l3_mux_c", 64'(l3_mc), 64'hFC);
        chk("main_mux_c", 64'(mux_C_sel_o), 64'hFC);

        // Single run with a one-cycle start pulse
        @(posedge clock_i);
        #1 start_i = 1'b1;
        @(posedge clock_i);
        #1 start_i = 1'b0;
        rec_base = cyc - 1;
        rec_on = 1'b1;
        repeat (45) @(posedge clock_i);
        #1 rec_on = 1'b0;
        chk("pe0_a_first", 64'(a_first[0]), 64'd2);
        chk("pe1_a_first", 64'(a_first[1]), 64'd11);
        chk("pe3_a_first", 64'(a_first[3]), 64'd29);
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("done_cycle", 64'(done_rel), 64'd39);
        chk("rd_first", 64'(rd_first), 64'd1);
        chk("rd_last", 64'(rd_last), 64'd4);
        chk("idx_last", 64'(idx_last), 64'd3);
        chk("pe0_op_k0", 64'(hist[0][2]), 64'h005);
        chk("pe0_op_k1", 64'(hist[0][3]), 64'h035);
        chk("pe0_op_k2", 64'(hist[0][4]), 64'h0A5);
        chk("pe0_op_end", 64'(hist[0][8]), 64'h000);
        for (int i = 0; i < S; i++) begin
            bit same;
            chk($sformatf("m_once_pe%0d", i), 64'(m_cnt[i]), 64'd1);
            same = 1'b1;
            for (int j = 0; j + PD * i < 64; j++)
                if (hist[i][j + PD * i] !== hist[0][j])
                    same = 1'b0;
            chk($sformatf("stagger_pe%0d", i), 64'(same), 64'd1);
        end

        // start held through RUN and the DONE cycle, then a back-to-back start
        td = total_done;
        @(posedge clock_i);
        #1 start_i = 1'b1;
        repeat (D + 1) @(posedge clock_i);
        #1 start_i = 1'b0;
        @(posedge clock_i);
        #1 start_i = 1'b1;
        @(posedge clock_i);
        #1 start_i = 1'b0;
        repeat (D + 4) @(posedge clock_i);
        #1;
        chk("two_runs_done", 64'(total_done - td), 64'd2);
        chk("idle_after_runs", 64'(busy_o), 64'd0);

        // Reset in the middle of RUN
        td = total_done;
        @(posedge clock_i);
        #1 start_i = 1'b1;
        @(posedge clock_i);
        #1 start_i = 1'b0;
        a = cyc - 1;
        repeat (11) @(posedge clock_i);
        #1 reset_i = 1'b1;
        chk("reset_at_cycle12", 64'(cyc - a), 64'd12);
        @(posedge clock_i);
        #1 reset_i = 1'b0;
        @(negedge clock_i);
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_opmode", 64'(OPMODE_o), 64'd0);
        chk("abort_a_en", 64'(a_reg_en_o), 64'd0);
        repeat (D + 2) @(posedge clock_i);
        #1;
        chk("abort_no_done", 64'(total_done - td), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
